instr_encoder_loader: RTL and testbench



---
 rtl/instr_encoder_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes decoded instruction descriptors into RV32I words and writes them
// sequentially into instruction memory, one word every two cycles.
module instr_encoder_loader #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_cause
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_memWdata;
    logic [ADDR_W:0]     r_count;
    logic                r_term;
    logic                r_done;
    logic                r_err;
    logic [1:0]          r_errCause;
    logic [31:0]         w_encoded;
    logic [11:0]         w_immUpper;
    logic                w_accept;
    logic                w_legal;
    logic                w_term;
    logic                w_lastSlot;

    assign w_accept   = in_valid && (r_state == S_LOAD);
    assign w_legal    = (in_class <= 4'd8);
    assign w_term     = in_last || (in_class == 4'd8);
    assign w_lastSlot = (r_count == LAST_SLOT);

    // Shift-immediate forms carry funct7 in the upper immediate bits.
    assign w_immUpper = ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) ?
                        {in_funct7, in_imm[4:0]} : in_imm[11:0];

    always_comb begin
        w_encoded = '0;
        case (in_class)
            4'd0: w_encoded = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            4'd1: w_encoded = {w_immUpper, in_rs1, in_funct3, in_rd, 7'b0010011};
            4'd2: w_encoded = {in_imm[31:12], in_rd, 7'b0110111};
            4'd3: w_encoded = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            4'd4: w_encoded = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            4'd5: w_encoded = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], 7'b1100011};
            4'd6: w_encoded = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, 7'b1101111};
            4'd7: w_encoded = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            4'd8: w_encoded = 32'h0000_0001;
            default: w_encoded = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    w_nextState = w_legal ? S_WRITE : S_ERR;
                end
            end
            S_WRITE: begin
                if (r_term) begin
                    w_nextState = S_DONE;
                end else if (w_lastSlot) begin
                    w_nextState = S_ERR;
                end else begin
                    w_nextState = S_LOAD;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    w_nextState = S_LOAD;
                end
            end
            default: w_nextState = S_LOAD;
        endcase
    end

    // Address and data are captured at the handshake so they hold after WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_count    <= '0;
            r_term     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errCause <= 2'b00;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_memAddr  <= r_count[ADDR_W-1:0];
                            r_memWdata <= w_encoded;
                            r_term     <= w_term;
                        end else begin
                            r_err      <= 1'b1;
                            r_errCause <= 2'b01;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + (ADDR_W + 1)'(1);
                    if (r_term) begin
                        r_done <= 1'b1;
                    end else if (w_lastSlot) begin
                        r_err      <= 1'b1;
                        r_errCause <= 2'b10;
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_errCause <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign count     = r_count;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cause = r_errCause;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a
// transaction-level reference model; a small ADDR_W makes overflow reachable.
module tb_instr_encoder_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_class;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          restart;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;
    logic [1:0]    err_cause;

    int checkCount = 0;
    int passCount  = 0;
    bit chkEn      = 1'b0;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .done(done), .err(err), .err_cause(err_cause)
    );

    always #5 clk = ~clk;

    // Reference encoding built with shifts and masks on plain integers.
    function automatic logic [31:0] encode(input logic [3:0] c, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] d, s1, s2, t3, t7, up;
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        t3 = 32'(f3) << 12;
        t7 = 32'(f7) << 25;
        case (c)
            4'd0: return t7 | s2 | s1 | t3 | d | 32'h33;
            4'd1: begin
                up = (f3 == 3'd1 || f3 == 3'd5) ? ((32'(f7) << 5) | (imm & 32'h1F)) : (imm & 32'hFFF);
                return (up << 20) | s1 | t3 | d | 32'h13;
            end
            4'd2: return (imm & 32'hFFFF_F000) | d | 32'h37;
            4'd3: return ((imm & 32'hFFF) << 20) | s1 | (32'd2 << 12) | d | 32'h03;
            4'd4: return (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | (32'd2 << 12) |
                         ((imm & 32'h1F) << 7) | 32'h23;
            4'd5: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | t3 |
                         (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            4'd6: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                         (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
            4'd7: return ((imm & 32'hFFF) << 20) | s1 | d | 32'h67;
            default: return 32'd1;
        endcase
    endfunction

    // Transaction-level model: one pending write at a time, sticky end states.
    bit          mPending, mTerm, mDone, mErr;
    logic [1:0]  mCause;
    logic [AW:0] mCount;
    logic [31:0] mLastAddr, mLastData;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPending = 0; mTerm = 0; mDone = 0; mErr = 0; mCause = 0;
            mCount = 0; mLastAddr = 0; mLastData = 0;
        end else if (mPending) begin
            mPending = 0;
            mCount = mCount + 1;
            if (mTerm) mDone = 1;
            else if (int'(mCount) == DEPTH) begin
                mErr = 1; mCause = 2;
            end
        end else if (mDone || mErr) begin
            if (restart) begin
                mDone = 0; mErr = 0; mCause = 0; mCount = 0;
            end
        end else if (in_valid) begin
            if (in_class > 4'd8) begin
                mErr = 1; mCause = 1;
            end else begin
                mPending  = 1;
                mLastAddr = int'(mCount) % DEPTH;
                mLastData = encode(in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                mTerm     = in_last || (in_class == 4'd8);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (chkEn && !reset) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!mPending && !mDone && !mErr));
            checkOutput("mem_we", 32'(mem_we), 32'(mPending));
            checkOutput("mem_addr", 32'(mem_addr), mLastAddr);
            checkOutput("mem_wdata", mem_wdata, mLastData);
            checkOutput("count", 32'(count), 32'(mCount));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("err", 32'(err), 32'(mErr));
            checkOutput("err_cause", 32'(err_cause), 32'(mCause));
        end
    end

    // Presents one descriptor for one cycle; returns at the negedge after the handshake edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input logic last);
        @(negedge clk);
        in_class = c; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulseRestart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 0; in_class = 0; in_funct3 = 0; in_funct7 = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_last = 0; restart = 0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_flags", {29'd0, done, err_cause}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chkEn = 1'b1;

        // addi x1,x0,5
        applyStimulus(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        checkOutput("addi_we", 32'(mem_we), 32'd1);
        checkOutput("addi_addr", 32'(mem_addr), 32'd0);
        checkOutput("addi_data", mem_wdata, 32'h0050_0093);
        @(negedge clk);
        checkOutput("addi_count", 32'(count), 32'd1);
        checkOutput("addi_ready", 32'(in_ready), 32'd1);

        // lui, sw, beq, then HALT at address 3
        doReset();
        applyStimulus(4'd2, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        checkOutput("lui_data", mem_wdata, 32'h1234_52B7);
        checkOutput("lui_ready", 32'(in_ready), 32'd0);
        applyStimulus(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        checkOutput("sw_addr", 32'(mem_addr), 32'd1);
        checkOutput("sw_data", mem_wdata, 32'h0020_A423);
        checkOutput("sw_ready", 32'(in_ready), 32'd0);
        applyStimulus(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
        checkOutput("beq_data", mem_wdata, 32'hFE20_8CE3);
        applyStimulus(4'd8, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        checkOutput("halt_addr", 32'(mem_addr), 32'd3);
        checkOutput("halt_data", mem_wdata, 32'h0000_0001);
        @(negedge clk);
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_count", 32'(count), 32'd4);
        in_class = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("done_ignores_valid", 32'(mem_we), 32'd0);
        end
        in_valid = 1'b0;
        pulseRestart();
        checkOutput("restart_ready", 32'(in_ready), 32'd1);
        checkOutput("restart_count", 32'(count), 32'd0);

        // jal x1,16
        applyStimulus(4'd6, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
        checkOutput("jal_addr", 32'(mem_addr), 32'd0);
        checkOutput("jal_data", mem_wdata, 32'h0100_00EF);

        // illegal class
        applyStimulus(4'hF, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        checkOutput("illegal_we", 32'(mem_we), 32'd0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_cause", 32'(err_cause), 32'd1);
        pulseRestart();

        // overflow with DEPTH non-terminating descriptors
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(4'd1, 3'd0, 7'd0, 5'($urandom), 5'($urandom), 5'd0, $urandom, 1'b0);
        end
        checkOutput("ovf_last_addr", 32'(mem_addr), 32'(DEPTH - 1));
        @(negedge clk);
        checkOutput("ovf_err", 32'(err), 32'd1);
        checkOutput("ovf_cause", 32'(err_cause), 32'd2);
        checkOutput("ovf_count", 32'(count), 32'(DEPTH));
        pulseRestart();

        // randomized descriptors
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if ($urandom_range(0, 9) == 0) pulseRestart();
            applyStimulus(4'($urandom_range(0, 10)), 3'($urandom), 7'($urandom), 5'($urandom),
                          5'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
            @(negedge clk);
            if (mDone || mErr) begin
                if ($urandom_range(0, 1) == 0) begin
                    in_valid = 1'b1;
                    @(negedge clk);
                    in_valid = 1'b0;
                end
                pulseRestart();
            end
        end

        // reset in the middle of a WRITE cycle
        doReset();
        applyStimulus(4'd0, 3'd7, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0);
        applyStimulus(4'd1, 3'd0, 7'd0, 5'd6, 5'd7, 5'd0, 32'h7FF, 1'b0);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_data", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
